sevenseg_scan: RTL and testbench

- Drives the 4-digit multiplexed seven-segment display from the stopwatch counter's BCD outputs (minutes_top/bot, seconds_top/bot).
- Time-multiplexes the anodes and decodes BCD to active-low segments.
- Shows a decimal point between minutes and seconds.
- In adjust mode, blinks the selected digit pair.
- Sits between the counter and the board display pins; single clock domain.

---
 rtl/sevenseg_scan.sv | 119 +++++++++++
 tb/tb_sevenseg_scan.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/sevenseg_scan.sv
// sevenseg_scan: 4-digit multiplexed seven-segment driver for the stopwatch.
// Scans the anodes and decodes BCD to active-low segments. The decimal point
// sits between minutes and seconds. In adjust mode the selected pair blinks.
// Optional feature macro: LEADING_ZERO_BLANK_EN blanks a leading '0' on minutes tens.
module sevenseg_scan #(
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 25000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] minutes_top_digit,
    input  logic [3:0] minutes_bot_digit,
    input  logic [3:0] seconds_top_digit,
    input  logic [3:0] seconds_bot_digit,
    input  logic       adj,
    input  logic       sel,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an
);
    localparam int RW = $clog2(REFRESH_DIV);
    localparam int BW = $clog2(BLINK_DIV);

    logic [RW-1:0]   refresh_cnt_q, refresh_cnt_d;
    logic [1:0]      slot_q, slot_d;
    logic [BW-1:0]   blink_cnt_q, blink_cnt_d;
    logic            blink_phase_q, blink_phase_d;
    // Index 0 = seconds_bot ... 3 = minutes_top, the same order as the slots.
    logic [3:0][3:0] snap_q, snap_d;
    logic [6:0]      seg_q, seg_d;
    logic            dp_q, dp_d;
    logic [3:0]      an_q, an_d;

    logic refresh_tc;
    logic blank;

    // BCD to active-low {g,f,e,d,c,b,a}. Non-BCD codes show nothing.
    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'b1000000;
            4'd1:    decode = 7'b1111001;
            4'd2:    decode = 7'b0100100;
            4'd3:    decode = 7'b0110000;
            4'd4:    decode = 7'b0011001;
            4'd5:    decode = 7'b0010010;
            4'd6:    decode = 7'b0000010;
            4'd7:    decode = 7'b1111000;
            4'd8:    decode = 7'b0000000;
            4'd9:    decode = 7'b0010000;
            default: decode = 7'b1111111;
        endcase
    endfunction

    // Scan timing, snapshot capture and blink timebase.
    always_comb begin
        refresh_tc    = (refresh_cnt_q == RW'(REFRESH_DIV - 1));
        refresh_cnt_d = refresh_tc ? '0 : refresh_cnt_q + 1'b1;
        slot_d        = refresh_tc ? slot_q + 2'd1 : slot_q;
        snap_d        = snap_q;
        // Capture all four digits together as the scan returns to slot 0,
        // so a frame never mixes old and new digits.
        if (refresh_tc && slot_q == 2'd3)
            snap_d = {minutes_top_digit, minutes_bot_digit,
                      seconds_top_digit, seconds_bot_digit};
        blink_cnt_d   = '0;
        blink_phase_d = 1'b0;
        // Outside adjust mode the blink timebase sits at zero, so entering
        // adjust always starts with a full visible half-period.
        if (adj) begin
            if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
                blink_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d   = blink_cnt_q + 1'b1;
                blink_phase_d = blink_phase_q;
            end
        end
    end

    // Output next-state: anode, segments and decimal point for the current slot.
    always_comb begin
        // slot_q[1] is 0 for the seconds pair, 1 for the minutes pair.
        blank = adj && blink_phase_q && (sel ? ~slot_q[1] : slot_q[1]);
`ifdef LEADING_ZERO_BLANK_EN
        if (slot_q == 2'd3 && snap_q[3] == 4'd0)
            blank = 1'b1;
`endif
        an_d  = blank ? 4'b1111 : ~(4'b0001 << slot_q);
        seg_d = blank ? 7'b1111111 : decode(snap_q[slot_q]);
        dp_d  = blank ? 1'b1 : (slot_q != 2'd2);
    end

    // State and registered outputs; reset blanks the display at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            refresh_cnt_q <= '0;
            slot_q        <= 2'd0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            snap_q        <= '0;
            seg_q         <= 7'b1111111;
            dp_q          <= 1'b1;
            an_q          <= 4'b1111;
        end else begin
            refresh_cnt_q <= refresh_cnt_d;
            slot_q        <= slot_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            snap_q        <= snap_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
            an_q          <= an_d;
        end
    end

    assign seg = seg_q;
    assign dp  = dp_q;
    assign an  = an_q;
endmodule

// File: tb/tb_sevenseg_scan.sv
// Directed bench for sevenseg_scan (REFRESH_DIV=4, BLINK_DIV=16).
// Stimulus pushes expected display states tagged with the clock count at
// which they must appear; a monitor pops and compares them on falling edges.
module tb_sevenseg_scan;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] mt = 4'd0, mb = 4'd0, st = 4'd0, sb = 4'd0;
    logic       adj = 1'b0, sel = 1'b0;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;

    sevenseg_scan #(.REFRESH_DIV(4), .BLINK_DIV(16)) dut (
        .clk(clk), .rst(rst),
        .minutes_top_digit(mt), .minutes_bot_digit(mb),
        .seconds_top_digit(st), .seconds_bot_digit(sb),
        .adj(adj), .sel(sel),
        .seg(seg), .dp(dp), .an(an)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         c;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        string      nm;
    } exp_t;
    exp_t q[$];

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                           S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                           S6 = 7'b0000010, S7 = 7'b1111000, S8 = 7'b0000000,
                           S9 = 7'b0010000, SB = 7'b1111111;

    task automatic push_exp(input int c, input logic [3:0] a, input logic [6:0] s,
                            input logic d, input string nm);
        exp_t e;
        e.c = c; e.an = a; e.seg = s; e.dp = d; e.nm = nm;
        q.push_back(e);
    endtask

    task automatic at_cyc(input int p);
        while (cyc < p) @(negedge clk);
        #1;
    endtask

    // Monitor: compare every expectation due at this clock count.
    initial begin
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].c <= cyc) begin
                n_cmp++;
                if (q[0].c < cyc) begin
                    n_bad++;
                    $display("FAIL %s: expectation for cycle %0d missed (now %0d)", q[0].nm, q[0].c, cyc);
                end else if (an !== q[0].an || seg !== q[0].seg || dp !== q[0].dp) begin
                    n_bad++;
                    $display("FAIL %s cyc=%0d: got an=%b seg=%b dp=%b, want an=%b seg=%b dp=%b",
                             q[0].nm, cyc, an, seg, dp, q[0].an, q[0].seg, q[0].dp);
                end
                void'(q.pop_front());
            end
        end
    end

    int r;

    initial begin
        // Reset held from time 0.
        push_exp(1, 4'b1111, SB, 1'b1, "rst_hold1");
        push_exp(3, 4'b1111, SB, 1'b1, "rst_hold3");
        at_cyc(3);
        rst = 1'b0;
        r = 3;

        // Frame 0 shows the cleared snapshot.
        push_exp(r + 1,  4'b1110, S0, 1'b1, "rel_slot0");
        push_exp(r + 4,  4'b1110, S0, 1'b1, "rel_slot0_end");
        push_exp(r + 5,  4'b1101, S0, 1'b1, "rel_slot1");
        push_exp(r + 9,  4'b1011, S0, 1'b0, "rel_slot2_dp");
`ifdef LEADING_ZERO_BLANK_EN
        push_exp(r + 13, 4'b1111, SB, 1'b1, "rel_slot3_lzb");
`else
        push_exp(r + 13, 4'b0111, S0, 1'b1, "rel_slot3");
`endif
        // Digits 1,2,3,4 -> captured at n=16, shown in frame 1.
        at_cyc(r + 1);
        mt = 4'd1; mb = 4'd2; st = 4'd3; sb = 4'd4;
        push_exp(r + 17, 4'b1110, S4, 1'b1, "f1_slot0");
        push_exp(r + 21, 4'b1101, S3, 1'b1, "f1_slot1");
        push_exp(r + 25, 4'b1011, S2, 1'b0, "f1_slot2");
        push_exp(r + 29, 4'b0111, S1, 1'b1, "f1_slot3");

        // seconds_bot changes mid-frame 2 at slot 1: no effect until the wrap.
        at_cyc(r + 37);
        sb = 4'd7;
        push_exp(r + 38, 4'b1101, S3, 1'b1, "mid_slot1");
        push_exp(r + 41, 4'b1011, S2, 1'b0, "mid_slot2");
        push_exp(r + 45, 4'b0111, S1, 1'b1, "mid_slot3");
        push_exp(r + 49, 4'b1110, S7, 1'b1, "wrap_slot0");

        // Illegal BCD on seconds_top: segments blank, anode still driven.
        at_cyc(r + 50);
        st = 4'd12;
        push_exp(r + 65, 4'b1110, S7, 1'b1, "bad_bcd_slot0");
        push_exp(r + 69, 4'b1101, SB, 1'b1, "bad_bcd_slot1");

        // Blink minutes pair: adj seen at n=81, phase high for outputs n=97..112.
        at_cyc(r + 80);
        adj = 1'b1; sel = 1'b0;
        push_exp(r + 81,  4'b1110, S7, 1'b1, "blk_vis_slot0");
        push_exp(r + 89,  4'b1011, S2, 1'b0, "blk_vis_slot2");
        push_exp(r + 96,  4'b0111, S1, 1'b1, "blk_vis_last");
        push_exp(r + 97,  4'b1110, S7, 1'b1, "blk_on_slot0");
        push_exp(r + 101, 4'b1101, SB, 1'b1, "blk_on_slot1");
        push_exp(r + 105, 4'b1111, SB, 1'b1, "blk_on_slot2");
        push_exp(r + 109, 4'b1111, SB, 1'b1, "blk_on_slot3");
        push_exp(r + 113, 4'b1110, S7, 1'b1, "blk_off_slot0");
        // Switch to seconds pair while phase is low; next blank half hits slots 0,1.
        at_cyc(r + 120);
        sel = 1'b1;
        push_exp(r + 129, 4'b1111, SB, 1'b1, "sel_slot0");
        push_exp(r + 133, 4'b1111, SB, 1'b1, "sel_slot1");
        push_exp(r + 137, 4'b1011, S2, 1'b0, "sel_slot2");
        // Leaving adjust mode makes everything visible on the next update.
        at_cyc(r + 140);
        adj = 1'b0;
        push_exp(r + 141, 4'b0111, S1, 1'b1, "adj_off_slot3");

        // Digits 0,5,3,0: leading-zero handling on slot 3.
        mt = 4'd0; mb = 4'd5; st = 4'd3; sb = 4'd0;
        push_exp(r + 145, 4'b1110, S0, 1'b1, "lz_slot0");
        push_exp(r + 149, 4'b1101, S3, 1'b1, "lz_slot1");
        push_exp(r + 153, 4'b1011, S5, 1'b0, "lz_slot2");
`ifdef LEADING_ZERO_BLANK_EN
        push_exp(r + 157, 4'b1111, SB, 1'b1, "lz_slot3_blank");
`else
        push_exp(r + 157, 4'b0111, S0, 1'b1, "lz_slot3_zero");
`endif

        // Mid-frame reset blanks immediately and clears the snapshot.
        at_cyc(r + 162);
        rst = 1'b1;
        push_exp(r + 163, 4'b1111, SB, 1'b1, "rst_mid");
        at_cyc(r + 164);
        rst = 1'b0;
        r = r + 164;
        push_exp(r + 1, 4'b1110, S0, 1'b1, "rst2_slot0");
        push_exp(r + 5, 4'b1101, S0, 1'b1, "rst2_slot1");

        // Remaining digit patterns 8,9,6,5.
        at_cyc(r + 1);
        mt = 4'd8; mb = 4'd9; st = 4'd6; sb = 4'd5;
        push_exp(r + 17, 4'b1110, S5, 1'b1, "f_slot0_5");
        push_exp(r + 21, 4'b1101, S6, 1'b1, "f_slot1_6");
        push_exp(r + 25, 4'b1011, S9, 1'b0, "f_slot2_9");
        push_exp(r + 29, 4'b0111, S8, 1'b1, "f_slot3_8");

        for (int i = 0; i < 200 && q.size() > 0; i++) @(negedge clk);
        #1;
        if (q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout: %0d expectations left, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
